game_control: RTL and testbench
===============================

GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 ATTACK_FRAMES, 8, number of frame_tick pulses the attack state is held (1..255).
REQ-002 DRAW_TIMEOUT, 131072, cycle limit for one draw phase when the watchdog is compiled in (2..2^20).
REQ-003 clock  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse at frame rate.
REQ-006 btn_up, btn_down, btn_left, btn_right, btn_attack  input  1 each  already synchronized, active-high button levels.
REQ-007 draw_map_done  input  1  map draw complete.
REQ-008 draw_link_done  input  1  character draw complete.
REQ-009 init, idle, attack, up, down, left, right, draw_map, draw_link  output  1 each  one-hot state commands to the datapath.
REQ-010 state_code  output  4  encoding of the current state, for LEDs.
REQ-011 draw_timeout  output  1  sticky watchdog error flag.

Function
REQ-012 The block SHALL be a Moore FSM with states S_RESET(0), S_INIT(1), S_DRAW_MAP(2), S_DRAW_LINK(3), S_IDLE(4), S_ATTACK(5), S_UP(6), S_DOWN(7), S_LEFT(8), S_RIGHT(9).
REQ-013 state_code SHALL equal the state number given in REQ-012.
REQ-014 Outputs SHALL be registered-state decodes: at most one command output is high in any cycle, and all are low in S_RESET.
REQ-015 S_RESET SHALL go to S_INIT on the first edge with reset low.
REQ-016 S_INIT SHALL assert init for exactly one cycle, then go to S_DRAW_MAP.
REQ-017 S_DRAW_MAP SHALL assert draw_map and stay until draw_map_done is sampled high, then go to S_DRAW_LINK on that edge.
REQ-018 S_DRAW_LINK SHALL assert draw_link and stay until draw_link_done is sampled high, then go to S_IDLE.
REQ-019 Done inputs SHALL be ignored outside their own draw state.
REQ-020 S_IDLE SHALL assert idle; buttons SHALL be sampled only on cycles with frame_tick=1.
REQ-021 On a sampled frame_tick, the next state SHALL follow the priority attack > up > down > left > right; with no button pressed the FSM stays in S_IDLE.
REQ-022 S_UP, S_DOWN, S_LEFT and S_RIGHT SHALL each last exactly one cycle with their output high, then go to S_DRAW_MAP.
REQ-023 S_ATTACK SHALL hold attack high, count frame_tick pulses in an 8-bit counter cleared on entry, and go to S_DRAW_MAP on the cycle the ATTACK_FRAMES-th pulse is seen.
REQ-024 frame_tick pulses outside S_IDLE and S_ATTACK SHALL be discarded, not queued.
REQ-025 A button change between frame_tick pulses SHALL have no effect.

Reset
REQ-026 reset high at any edge, in any state and mid-draw included, SHALL force S_RESET, clear the attack and watchdog counters, and clear draw_timeout.
REQ-027 While reset is high, all command outputs SHALL be 0, state_code SHALL be 0 and draw_timeout SHALL be 0.

Configuration
REQ-028 With GAME_CONTROL_WATCHDOG_EN defined, a 20-bit counter SHALL count cycles spent in S_DRAW_MAP or S_DRAW_LINK and clear on each state entry.
REQ-029 When that counter reaches DRAW_TIMEOUT-1 without the done input, the FSM SHALL advance as if done was received and set draw_timeout, which stays high until reset.
REQ-030 Without GAME_CONTROL_WATCHDOG_EN, the draw states SHALL wait indefinitely, no counter SHALL be built, and draw_timeout SHALL be tied to 0.

Verification
REQ-031 Reset then release -> S_RESET 1+ cycles, init high exactly 1 cycle, then draw_map high; state_code 0->1->2.
REQ-032 draw_map_done pulse after 50 cycles -> draw_link high next cycle; draw_link_done pulse -> idle high, state_code=4.
REQ-033 In S_IDLE, btn_up=btn_left=btn_attack=1 with no frame_tick for 100 cycles -> stays idle; then frame_tick -> attack for exactly 8 frame_tick pulses, then draw_map.
REQ-034 In S_IDLE, btn_down=btn_right=1 plus frame_tick -> down high for 1 cycle, then draw_map; a second frame_tick during S_DRAW_MAP -> ignored.
REQ-035 reset asserted for 1 cycle mid S_DRAW_LINK -> all outputs 0 next cycle, then the init sequence restarts.
REQ-036 With the watchdog macro and DRAW_TIMEOUT=16, draw_map_done never sent -> draw_link asserted after 16 cycles in S_DRAW_MAP and draw_timeout=1 until reset; without the macro -> remains in S_DRAW_MAP and draw_timeout=0.

Source files
------------

// File: rtl/game_control_if.sv
// Signal bundle between game_control (slave) and the datapath or stimulus side (master):
// frame tick, buttons and draw-done strobes go in; one-hot commands, state code and error flag come out.
interface game_control_if;
    logic       frame_tick;
    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_attack;
    logic       draw_map_done;
    logic       draw_link_done;
    logic       init;
    logic       idle;
    logic       attack;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       draw_map;
    logic       draw_link;
    logic [3:0] state_code;
    logic       draw_timeout;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
        output draw_map_done, draw_link_done,
        input  init, idle, attack, up, down, left, right, draw_map, draw_link,
        input  state_code, draw_timeout
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
        input  draw_map_done, draw_link_done,
        output init, idle, attack, up, down, left, right, draw_map, draw_link,
        output state_code, draw_timeout
    );
endinterface

// File: rtl/game_control.sv
// Game control Moore FSM: one-hot commands are registered state decodes (valid the cycle the state is entered), no backpressure.
// Optional draw-phase watchdog is built only when GAME_CONTROL_WATCHDOG_EN is defined.
module game_control #(
    parameter int unsigned ATTACK_FRAMES = 8,
    parameter int unsigned DRAW_TIMEOUT  = 131072
) (
    input  logic          clock,
    input  logic          reset,
    game_control_if.slave io
);
    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_INIT      = 4'd1,
        S_DRAW_MAP  = 4'd2,
        S_DRAW_LINK = 4'd3,
        S_IDLE      = 4'd4,
        S_ATTACK    = 4'd5,
        S_UP        = 4'd6,
        S_DOWN      = 4'd7,
        S_LEFT      = 4'd8,
        S_RIGHT     = 4'd9
    } state_t;

    localparam logic [7:0] ATK_LAST = 8'(ATTACK_FRAMES - 1);

    if (ATTACK_FRAMES < 1 || ATTACK_FRAMES > 255) begin : g_bad_attack_frames
        $error("game_control: ATTACK_FRAMES must be 1..255");
    end
    if (DRAW_TIMEOUT < 2 || DRAW_TIMEOUT > 1048576) begin : g_bad_draw_timeout
        $error("game_control: DRAW_TIMEOUT must be 2..2^20");
    end

    state_t     state_q, state_d;
    logic [7:0] atk_cnt_q, atk_cnt_d;
    logic [8:0] cmd_q;
    logic       wd_expired;

    // Command bit order: {init, idle, attack, up, down, left, right, draw_map, draw_link}
    function automatic logic [8:0] decode(input state_t s);
        logic [8:0] c;
        c = '0;
        case (s)
            S_INIT:      c[8] = 1'b1;
            S_IDLE:      c[7] = 1'b1;
            S_ATTACK:    c[6] = 1'b1;
            S_UP:        c[5] = 1'b1;
            S_DOWN:      c[4] = 1'b1;
            S_LEFT:      c[3] = 1'b1;
            S_RIGHT:     c[2] = 1'b1;
            S_DRAW_MAP:  c[1] = 1'b1;
            S_DRAW_LINK: c[0] = 1'b1;
            default:     c    = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d   = state_q;
        atk_cnt_d = atk_cnt_q;
        case (state_q)
            S_RESET:     state_d = S_INIT;
            S_INIT:      state_d = S_DRAW_MAP;
            S_DRAW_MAP:  if (io.draw_map_done || wd_expired) state_d = S_DRAW_LINK;
            S_DRAW_LINK: if (io.draw_link_done || wd_expired) state_d = S_IDLE;
            S_IDLE: begin
                if (io.frame_tick) begin
                    atk_cnt_d = '0;
                    if (io.btn_attack)     state_d = S_ATTACK;
                    else if (io.btn_up)    state_d = S_UP;
                    else if (io.btn_down)  state_d = S_DOWN;
                    else if (io.btn_left)  state_d = S_LEFT;
                    else if (io.btn_right) state_d = S_RIGHT;
                end
            end
            S_ATTACK: begin
                if (io.frame_tick) begin
                    if (atk_cnt_q == ATK_LAST) state_d = S_DRAW_MAP;
                    else                       atk_cnt_d = atk_cnt_q + 8'd1;
                end
            end
            S_UP, S_DOWN, S_LEFT, S_RIGHT: state_d = S_DRAW_MAP;
            default:     state_d = S_RESET;
        endcase
    end

    // Commands are decoded from the next state so they line up with state_q every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_RESET;
            atk_cnt_q <= '0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            atk_cnt_q <= atk_cnt_d;
            cmd_q     <= decode(state_d);
        end
    end

`ifdef GAME_CONTROL_WATCHDOG_EN
    localparam logic [19:0] WD_LAST = 20'(DRAW_TIMEOUT - 1);

    logic [19:0] wd_cnt_q;
    logic        timeout_q;
    logic        in_draw;
    logic        done_now;

    assign in_draw    = (state_q == S_DRAW_MAP) || (state_q == S_DRAW_LINK);
    assign done_now   = (state_q == S_DRAW_MAP) ? io.draw_map_done : io.draw_link_done;
    assign wd_expired = in_draw && (wd_cnt_q == WD_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_d != state_q) wd_cnt_q <= '0;
            else if (in_draw)       wd_cnt_q <= wd_cnt_q + 20'd1;
            if (wd_expired && !done_now) timeout_q <= 1'b1;
        end
    end

    assign io.draw_timeout = timeout_q;
`else
    assign wd_expired      = 1'b0;
    assign io.draw_timeout = 1'b0;
`endif

    assign {io.init, io.idle, io.attack, io.up, io.down,
            io.left, io.right, io.draw_map, io.draw_link} = cmd_q;
    assign io.state_code = state_q;
endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: walks reset, draw handshakes, button priority, attack timing,
// mid-draw reset and draw watchdog behaviour, comparing every output against hand-derived states.
module tb_game_control;
    logic clock;
    logic reset;
    int   total;
    int   passed;

    game_control_if gif();

    game_control #(
        .ATTACK_FRAMES(8),
        .DRAW_TIMEOUT (16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .io   (gif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected one-hot {init, idle, attack, up, down, left, right, draw_map, draw_link} for a state number.
    function automatic logic [8:0] exp_cmd(input int code);
        case (code)
            1:       return 9'b100000000;
            2:       return 9'b000000010;
            3:       return 9'b000000001;
            4:       return 9'b010000000;
            5:       return 9'b001000000;
            6:       return 9'b000100000;
            7:       return 9'b000010000;
            8:       return 9'b000001000;
            9:       return 9'b000000100;
            default: return 9'b000000000;
        endcase
    endfunction

    task automatic chk(input string tag, input int code, input logic to);
        logic [13:0] obs;
        logic [13:0] exp;
        obs = {gif.state_code, gif.init, gif.idle, gif.attack, gif.up, gif.down,
               gif.left, gif.right, gif.draw_map, gif.draw_link, gif.draw_timeout};
        exp = {4'(code), exp_cmd(code), to};
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed {code,cmd,to}=%b required %b", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        total  = 0;
        passed = 0;
        reset  = 1'b1;
        gif.frame_tick     = 1'b0;
        gif.btn_up         = 1'b0;
        gif.btn_down       = 1'b0;
        gif.btn_left       = 1'b0;
        gif.btn_right      = 1'b0;
        gif.btn_attack     = 1'b0;
        gif.draw_map_done  = 1'b0;
        gif.draw_link_done = 1'b0;

        step(3);
        chk("reset_held", 0, 1'b0);
        reset = 1'b0;
        step(1); chk("init_after_release", 1, 1'b0);
        step(1); chk("draw_map_after_init", 2, 1'b0);

        gif.draw_link_done = 1'b1;
        step(1); chk("link_done_ignored_in_map", 2, 1'b0);
        gif.draw_link_done = 1'b0;
        step(48); chk("map_waits_50", 2, 1'b0);
        gif.draw_map_done = 1'b1;
        step(1); chk("map_done_to_link", 3, 1'b0);
        gif.draw_map_done = 1'b1;
        step(1); chk("map_done_ignored_in_link", 3, 1'b0);
        gif.draw_map_done  = 1'b0;
        gif.draw_link_done = 1'b1;
        step(1); chk("link_done_to_idle", 4, 1'b0);
        gif.draw_link_done = 1'b0;

        gif.btn_up = 1'b1; gif.btn_left = 1'b1; gif.btn_attack = 1'b1;
        step(100); chk("idle_no_tick", 4, 1'b0);
        gif.frame_tick = 1'b1;
        step(1); chk("attack_priority", 5, 1'b0);
        gif.frame_tick = 1'b0;
        gif.btn_attack = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(2);
            gif.frame_tick = 1'b1;
            step(1);
            gif.frame_tick = 1'b0;
            chk($sformatf("attack_tick_%0d", i), (i < 8) ? 5 : 2, 1'b0);
        end
        gif.btn_up = 1'b0; gif.btn_left = 1'b0;

        gif.draw_map_done = 1'b1;
        step(1); gif.draw_map_done = 1'b0; gif.draw_link_done = 1'b1;
        step(1); gif.draw_link_done = 1'b0;
        chk("back_to_idle", 4, 1'b0);

        gif.btn_down = 1'b1; gif.btn_right = 1'b1; gif.frame_tick = 1'b1;
        step(1); gif.frame_tick = 1'b0;
        chk("down_over_right", 7, 1'b0);
        step(1); chk("down_one_cycle", 2, 1'b0);
        gif.frame_tick = 1'b1;
        step(1); gif.frame_tick = 1'b0;
        chk("tick_in_map_ignored", 2, 1'b0);
        gif.draw_map_done = 1'b1;
        step(1); gif.draw_map_done = 1'b0; gif.draw_link_done = 1'b1;
        step(1); gif.draw_link_done = 1'b0;
        step(3); chk("tick_not_queued", 4, 1'b0);

        gif.btn_down = 1'b0; gif.btn_right = 1'b0;
        gif.btn_left = 1'b1;
        step(2); gif.btn_left = 1'b0;
        step(1); chk("button_between_ticks", 4, 1'b0);
        gif.btn_up = 1'b1; gif.btn_right = 1'b1; gif.frame_tick = 1'b1;
        step(1); gif.frame_tick = 1'b0; gif.btn_up = 1'b0; gif.btn_right = 1'b0;
        chk("up_over_right", 6, 1'b0);
        step(1); chk("up_to_map", 2, 1'b0);
        gif.draw_map_done = 1'b1;
        step(1); gif.draw_map_done = 1'b0;
        chk("in_link_before_reset", 3, 1'b0);

        reset = 1'b1;
        step(1); reset = 1'b0;
        chk("reset_mid_link", 0, 1'b0);
        step(1); chk("restart_init", 1, 1'b0);
        step(1); chk("restart_map", 2, 1'b0);

`ifdef GAME_CONTROL_WATCHDOG_EN
        step(15); chk("wd_map_16th_cycle", 2, 1'b0);
        step(1);  chk("wd_map_timeout", 3, 1'b1);
        step(16); chk("wd_link_timeout_sticky", 4, 1'b1);
`else
        step(15); chk("no_wd_map_16th_cycle", 2, 1'b0);
        step(1);  chk("no_wd_map_stays", 2, 1'b0);
        step(16); chk("no_wd_map_still", 2, 1'b0);
`endif
        reset = 1'b1;
        step(1); chk("final_reset", 0, 1'b0);
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
